// File: rtl/fila_param_if.sv
// Handshake/status bundle for the fila_param circular FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface fila_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic             flush_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] head_out;
  logic [LW-1:0]    len_out;
  logic             full_out;
  logic             empty_out;
  logic             almost_full_out;
  logic             overflow_out;
  logic             underflow_out;

  modport master (
    output data_in, enqueue_in, dequeue_in, flush_in,
    input  data_out, head_out, len_out, full_out, empty_out,
           almost_full_out, overflow_out, underflow_out
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in, flush_in,
    output data_out, head_out, len_out, full_out, empty_out,
           almost_full_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/fila_param.sv
// Parametrised circular-buffer FIFO with simultaneous enqueue/dequeue,
// occupancy status, sticky overflow/underflow flags, flush and head peek.
module fila_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic        clk_10KHz,
  input logic        reset,
  fila_param_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty, do_enq, do_deq;

  always_comb begin
    full   = (len_q == LW'(DEPTH));
    empty  = (len_q == '0);
    do_deq = bus.dequeue_in && !bus.flush_in && !empty;
    // A same-edge read frees a slot, so a full queue still accepts the write.
    do_enq = bus.enqueue_in && !bus.flush_in && (!full || do_deq);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush_in) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      len_d       = '0;
      data_out_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_deq) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      if (do_enq && !do_deq) begin
        len_d = len_q + LW'(1);
      end else if (!do_enq && do_deq) begin
        len_d = len_q - LW'(1);
      end
      if (bus.enqueue_in && !bus.dequeue_in && full) begin
        overflow_d = 1'b1;
      end
      if (bus.dequeue_in && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden while empty.
  always_ff @(posedge clk_10KHz) begin
    if (do_enq) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out        = data_out_q;
  assign bus.head_out        = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.len_out         = len_q;
  assign bus.full_out        = full;
  assign bus.empty_out       = empty;
  assign bus.almost_full_out = (len_q >= LW'(AFULL_THRESH));
  assign bus.overflow_out    = overflow_q;
  assign bus.underflow_out   = underflow_q;
endmodule

// File: tb/tb_fila_param.sv
// Self-checking bench for fila_param: table-driven fill/overflow/drain plus
// hand-written wrap, simultaneous, flush and async-reset sequences on 8x8 and 16x16.
module tb_fila_param;
  logic clk_10KHz = 1'b0;
  logic reset     = 1'b0;

  always #5 clk_10KHz = ~clk_10KHz;

  fila_param_if #(.WIDTH(8),  .DEPTH(8))  bus8  ();
  fila_param_if #(.WIDTH(16), .DEPTH(16)) bus16 ();

  fila_param #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6)) dut8 (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus8)
  );

  fila_param #(.WIDTH(16), .DEPTH(16), .AFULL_THRESH(12)) dut16 (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus16)
  );

  typedef struct {
    bit          enq;
    bit          deq;
    bit          flush;
    logic [15:0] data;
    int          exp_len;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  int          sel;
  int          depth;
  int          thresh;
  logic [15:0] mask;

  logic [15:0] model[$];
  logic [15:0] sb[$];
  logic [15:0] last_dout;
  bit          m_ovf, m_udf, popped;

  logic [31:0] a_dout, a_head, a_len;
  logic        a_full, a_empty, a_afull, a_ovf, a_udf;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sampleDut();
    if (sel == 0) begin
      a_dout  = 32'(bus8.data_out);
      a_head  = 32'(bus8.head_out);
      a_len   = 32'(bus8.len_out);
      a_full  = bus8.full_out;
      a_empty = bus8.empty_out;
      a_afull = bus8.almost_full_out;
      a_ovf   = bus8.overflow_out;
      a_udf   = bus8.underflow_out;
    end else begin
      a_dout  = 32'(bus16.data_out);
      a_head  = 32'(bus16.head_out);
      a_len   = 32'(bus16.len_out);
      a_full  = bus16.full_out;
      a_empty = bus16.empty_out;
      a_afull = bus16.almost_full_out;
      a_ovf   = bus16.overflow_out;
      a_udf   = bus16.underflow_out;
    end
  endtask

  task automatic idleInputs();
    bus8.data_in     = '0;
    bus8.enqueue_in  = 1'b0;
    bus8.dequeue_in  = 1'b0;
    bus8.flush_in    = 1'b0;
    bus16.data_in    = '0;
    bus16.enqueue_in = 1'b0;
    bus16.dequeue_in = 1'b0;
    bus16.flush_in   = 1'b0;
  endtask

  task automatic selectDut(input int s);
    sel    = s;
    depth  = (s == 0) ? 8 : 16;
    thresh = (s == 0) ? 6 : 12;
    mask   = (s == 0) ? 16'h00FF : 16'hFFFF;
  endtask

  task automatic clearModel();
    model.delete();
    sb.delete();
    last_dout = '0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    popped    = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    clearModel();
    repeat (2) @(posedge clk_10KHz);
    @(negedge clk_10KHz);
    reset = 1'b1;
  endtask

  // Reference is an unbounded queue; expected dequeued words go to the scoreboard.
  task automatic applyStimulus(input bit enq, input bit deq, input bit flush, input logic [15:0] data);
    bit mfull, mempty;
    mfull  = (model.size() == depth);
    mempty = (model.size() == 0);
    popped = 1'b0;
    if (flush) begin
      model.delete();
      sb.delete();
      last_dout = '0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
    end else begin
      if (deq && !mempty) begin
        sb.push_back(model.pop_front());
        popped = 1'b1;
      end
      if (enq && (!mfull || deq)) model.push_back(data & mask);
      if (enq && mfull && !deq) m_ovf = 1'b1;
      if (deq && mempty) m_udf = 1'b1;
    end
    if (sel == 0) begin
      bus8.data_in    = data[7:0];
      bus8.enqueue_in = enq;
      bus8.dequeue_in = deq;
      bus8.flush_in   = flush;
    end else begin
      bus16.data_in    = data;
      bus16.enqueue_in = enq;
      bus16.dequeue_in = deq;
      bus16.flush_in   = flush;
    end
    @(posedge clk_10KHz);
    #1;
    idleInputs();
  endtask

  task automatic checkOutput();
    int n;
    sampleDut();
    if (popped && sb.size() > 0) last_dout = sb.pop_front();
    n = model.size();
    checkValue("data_out", a_dout, 32'(last_dout));
    checkValue("len_out", a_len, 32'(n));
    checkValue("full_out", 32'(a_full), 32'(n == depth));
    checkValue("empty_out", 32'(a_empty), 32'(n == 0));
    checkValue("almost_full_out", 32'(a_afull), 32'(n >= thresh));
    checkValue("head_out", a_head, (n > 0) ? 32'(model[0]) : 32'h0);
    checkValue("overflow_out", 32'(a_ovf), 32'(m_ovf));
    checkValue("underflow_out", 32'(a_udf), 32'(m_udf));
  endtask

  task automatic step(input bit enq, input bit deq, input bit flush, input logic [15:0] data);
    applyStimulus(enq, deq, flush, data);
    checkOutput();
  endtask

  initial begin
    logic [15:0] d;
    idleInputs();
    selectDut(0);
    clearModel();

    for (int i = 0; i < 8; i++)
      vecs.push_back('{enq: 1'b1, deq: 1'b0, flush: 1'b0, data: 16'(8'h11 + i), exp_len: i + 1, exp_ovf: 1'b0});
    vecs.push_back('{enq: 1'b1, deq: 1'b0, flush: 1'b0, data: 16'h0099, exp_len: 8, exp_ovf: 1'b1});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{enq: 1'b0, deq: 1'b1, flush: 1'b0, data: 16'h0000, exp_len: 7 - i, exp_ovf: 1'b1});

    doReset();
    sampleDut();
    checkValue("reset_len", a_len, 32'h0);
    checkValue("reset_empty", 32'(a_empty), 32'h1);
    checkValue("reset_head", a_head, 32'h0);
    checkValue("reset_dout", a_dout, 32'h0);

    // Fill, overflow attempt, drain in order.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].enq, vecs[i].deq, vecs[i].flush, vecs[i].data);
      checkOutput();
      checkValue("tbl_len", a_len, 32'(vecs[i].exp_len));
      checkValue("tbl_ovf", 32'(a_ovf), 32'(vecs[i].exp_ovf));
      if (i == 7) checkValue("tbl_head_full", a_head, 32'h11);
      if (vecs[i].deq) checkValue("tbl_dout", a_dout, 32'(8'h11 + i - 9));
    end

    // Pointer wrap-around.
    d = 16'h0030;
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, 1'b0, 1'b0, d);
        d = d + 16'd1;
      end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 16'h0);
    end
    checkValue("wrap_len_end", a_len, 32'h0);

    // Simultaneous enqueue/dequeue when full, then when empty.
    doReset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'(8'h40 + i));
    step(1'b1, 1'b1, 1'b0, 16'h00AA);
    checkValue("both_full_dout", a_dout, 32'h40);
    checkValue("both_full_ovf", 32'(a_ovf), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("drain_last", a_dout, 32'hAA);
    step(1'b1, 1'b1, 1'b0, 16'h00AA);
    checkValue("both_empty_len", a_len, 32'h1);
    checkValue("both_empty_udf", 32'(a_udf), 32'h1);
    checkValue("both_empty_dout_hold", a_dout, 32'hAA);

    // Flush with len=5, underflow set, and a colliding enqueue.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'(8'hC0 + i));
    step(1'b1, 1'b0, 1'b1, 16'h0055);
    checkValue("flush_len", a_len, 32'h0);
    checkValue("flush_dout", a_dout, 32'h0);
    checkValue("flush_udf", 32'(a_udf), 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0066);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("after_flush_dout", a_dout, 32'h66);

    // Asynchronous reset between edges with len=4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'(8'hD0 + i));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h00D4);
    #2;
    reset = 1'b0;
    #1;
    sampleDut();
    checkValue("async_len", a_len, 32'h0);
    checkValue("async_dout", a_dout, 32'h0);
    checkValue("async_empty", 32'(a_empty), 32'h1);
    checkValue("async_head", a_head, 32'h0);
    checkValue("async_afull", 32'(a_afull), 32'h0);
    doReset();

    // Wide/deep instance: full at 16, almost-full from 12.
    selectDut(1);
    clearModel();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(16'h1011 + i));
      if (i == 10) checkValue("w16_afull_11", 32'(a_afull), 32'h0);
      if (i == 11) checkValue("w16_afull_12", 32'(a_afull), 32'h1);
    end
    checkValue("w16_full", 32'(a_full), 32'h1);
    checkValue("w16_head", a_head, 32'h1011);
    step(1'b1, 1'b0, 1'b0, 16'h9999);
    checkValue("w16_ovf", 32'(a_ovf), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("w16_last", a_dout, 32'h1020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fila_param.md
# fila_param

Parametrised circular-buffer FIFO, successor to the fixed 8×8 shift-register queue. Adds configurable width and depth, simultaneous enqueue/dequeue in one cycle, full/empty/almost-full status, sticky overflow/underflow error flags, a synchronous flush and a combinational peek of the oldest entry. It sits between the input-capture logic and the display/consumer logic on the 10 kHz domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_THRESH, DEPTH-2, almost_full_out asserts when occupancy ≥ this value (1..DEPTH)
- LW (derived, not overridable), $clog2(DEPTH+1), occupancy counter width

- clk_10KHz  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  word to enqueue
- enqueue_in  in  1  enqueue request, sampled each rising edge
- dequeue_in  in  1  dequeue request, sampled each rising edge
- flush_in  in  1  synchronous clear of contents and error flags
- data_out  out  WIDTH  registered; last dequeued word
- head_out  out  WIDTH  combinational peek of oldest entry; 0 when empty
- len_out  out  LW  registered occupancy, 0..DEPTH
- full_out  out  1  len_out == DEPTH
- empty_out  out  1  len_out == 0
- almost_full_out  out  1  len_out ≥ AFULL_THRESH
- overflow_out  out  1  sticky; set by an enqueue dropped because the queue is full
- underflow_out  out  1  sticky; set by a dequeue rejected because the queue is empty

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits. Both wrap DEPTH-1 → 0 by natural overflow. No data shifting.
- Per-edge priority:
  - flush_in=1: wr_ptr, rd_ptr, len_out ← 0; data_out ← 0; overflow_out, underflow_out ← 0. enqueue_in and dequeue_in are ignored this cycle.
  - Enqueue only, not full: mem[wr_ptr] ← data_in; wr_ptr+1; len+1.
  - Enqueue only, full: word dropped; no state change except overflow_out ← 1.
  - Dequeue only, not empty: data_out ← mem[rd_ptr]; rd_ptr+1; len-1.
  - Dequeue only, empty: data_out holds; underflow_out ← 1.
  - Both, not empty (including full): data_out ← old head; mem[wr_ptr] ← data_in; both pointers advance; len unchanged. No overflow when full: the read frees a slot in the same edge.
  - Both, empty: enqueue accepted (len 0 → 1). Dequeue rejected and underflow_out ← 1. No bypass of data_in to data_out.
- Status flags are combinational decodes of the len_out register and change only with it.
- head_out = mem[rd_ptr] when len_out > 0, else 0.
- Sticky flags clear only on reset or flush_in.

## Timing
- Reset (reset=0, asynchronous, any time, including mid-operation): data_out=0, len_out=0, pointers=0, overflow_out=0, underflow_out=0. Hence empty_out=1, full_out=0, almost_full_out=0 (AFULL_THRESH ≥ 1), head_out=0. Array contents are not cleared; they are unobservable while empty.
- Reset deassertion is sampled at the next rising edge; the first operation takes effect on that edge.
- Enqueue at edge N: len_out, flags and head_out (if it becomes the head) update after edge N. The earliest dequeue of that word is edge N+1.
- Dequeue at edge N: data_out is valid after edge N and holds until the next successful dequeue, flush or reset.
- Throughput: one enqueue and one dequeue per cycle. len_out never exceeds DEPTH and never goes below 0.

## Test plan
- Reset, then enqueue 0x11..0x18 on 8 consecutive edges → len_out=8, full_out=1, almost_full_out=1 (reached at len=6), head_out=0x11.
- Full, enqueue 0x99 only → len stays 8, overflow_out=1 and stays set. Then dequeue 8 times → data_out 0x11..0x18 in order, with 0x99 absent. Then empty_out=1, head_out=0.
- Wrap-around: loop enqueue 3 / dequeue 3 for 5 iterations with incrementing data → every word returns in order across the pointer wrap, and len ends at 0.
- Simultaneous: with the queue full, apply enqueue 0xAA and dequeue together → data_out = old head, len stays 8, overflow_out stays 0. With the queue empty, apply both → len=1, head_out=0xAA, underflow_out=1.
- Flush with len=5 and underflow_out=1, enqueue_in=1 on the same edge → len=0, data_out=0, both sticky flags 0, data_in not stored.
- Assert reset asynchronously between edges with len=4 → all outputs reach reset values before the next edge. Rerun the first scenario with WIDTH=16, DEPTH=16, AFULL_THRESH=12 → full at 16, almost_full at 12.
